// File: rtl/hyper_burst_splitter.sv
// Splits arbiter-granted hyperbus commands into bursts that never cross a
// MAX_BURST-aligned boundary and issues them over a valid/ready interface.
module hyper_burst_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ID_WIDTH   = 1,
  parameter int MAX_BURST  = 128,
  parameter int BL_WIDTH   = $clog2(MAX_BURST) + 1,
  parameter int DATA_WIDTH = ADDR_WIDTH + LEN_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [BL_WIDTH-1:0]   cmd_len_o,
  output logic                  cmd_rw_o,
  output logic [ID_WIDTH-1:0]   cmd_id_o,
  output logic                  cmd_last_o,
  output logic                  busy_o
);
  localparam int CW = (LEN_WIDTH > BL_WIDTH) ? LEN_WIDTH : BL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(MAX_BURST - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic                  rw;
    logic [LEN_WIDTH-1:0]  len;
    logic [ADDR_WIDTH-1:0] addr;
  } cmd_t;

  state_t                state_q, state_d;
  cmd_t                  req_cmd;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  rw_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [BL_WIDTH-1:0]   room;
  logic [BL_WIDTH-1:0]   burst_len;
  logic                  is_last;
  logic                  issue;
  logic                  fire;

  assign req_cmd   = cmd_t'(data_i);
  assign issue     = (state_q == ISSUE);
  assign fire      = issue & cmd_ready_i;
  assign room      = BL_WIDTH'(MAX_BURST) - BL_WIDTH'(cur_addr & ADDR_MASK);
  assign is_last   = CW'(remaining) <= CW'(room);
  // remaining fits in BL_WIDTH whenever it is the selected length
  assign burst_len = is_last ? BL_WIDTH'(remaining) : room;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && req_cmd.len != '0) state_d = ISSUE;
      ISSUE:   if (cmd_ready_i && is_last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      rw_q      <= 1'b0;
      id_q      <= '0;
    end else if (state_q == IDLE && req_i) begin
      cur_addr  <= req_cmd.addr;
      remaining <= req_cmd.len;
      rw_q      <= req_cmd.rw;
      id_q      <= id_i;
    end else if (fire) begin
      cur_addr  <= cur_addr + ADDR_WIDTH'(burst_len);
      remaining <= remaining - LEN_WIDTH'(burst_len);
    end
  end

  // Outputs are zeroed outside ISSUE so an idle port shows no stale command.
  assign gnt_o       = (state_q == IDLE);
  assign cmd_valid_o = issue;
  assign busy_o      = issue;
  assign cmd_addr_o  = issue ? cur_addr  : '0;
  assign cmd_len_o   = issue ? burst_len : '0;
  assign cmd_last_o  = issue & is_last;
  assign cmd_rw_o    = issue & rw_q;
  assign cmd_id_o    = issue ? id_q : '0;
endmodule

// File: tb/tb_hyper_burst_splitter.sv
// Self-checking bench for hyper_burst_splitter: directed cases plus random
// commands compared against an arithmetic burst-list model.
module tb_hyper_burst_splitter;
  localparam int AW = 32, LW = 16, IW = 1, MB = 128;
  localparam int BW = $clog2(MB) + 1;
  localparam int DW = AW + LW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i;
  logic          gnt_o;
  logic [DW-1:0] data_i;
  logic [IW-1:0] id_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [AW-1:0] cmd_addr_o;
  logic [BW-1:0] cmd_len_o;
  logic          cmd_rw_o;
  logic [IW-1:0] cmd_id_o;
  logic          cmd_last_o;
  logic          busy_o;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    longint addr;
    int     len;
    bit     last;
  } burst_t;

  burst_t exp_q[$];

  hyper_burst_splitter #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ID_WIDTH(IW), .MAX_BURST(MB),
    .BL_WIDTH(BW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .data_i(data_i),
    .id_i(id_i), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o), .cmd_rw_o(cmd_rw_o),
    .cmd_id_o(cmd_id_o), .cmd_last_o(cmd_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Burst list straight from the splitting rule.
  task automatic model(input longint addr, input int len);
    longint a = addr;
    int rem = len;
    exp_q.delete();
    while (rem > 0) begin
      burst_t b;
      int room = MB - int'(a % MB);
      b.addr = a;
      b.len  = (rem < room) ? rem : room;
      b.last = (rem <= room);
      exp_q.push_back(b);
      a   = (a + b.len) % (64'd1 << AW);
      rem = rem - b.len;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".gnt"},   64'(gnt_o), 64'd1);
    chk({tag, ".valid"}, 64'(cmd_valid_o), 64'd0);
    chk({tag, ".busy"},  64'(busy_o), 64'd0);
  endtask

  // Called and returns at a negedge. mode: 0 ready high, 1 toggle 1/0, 2 random.
  // abort_at >= 0 asserts rst while that burst index is presented.
  task automatic run_cmd(input longint addr, input int len, input bit rw,
                         input logic [IW-1:0] id, input int mode, input int abort_at);
    int  cyc = 0;
    int  idx = 0;
    bit  tog = 1'b1;
    bit  r;
    model(addr, len);
    chk("accept.gnt", 64'(gnt_o), 64'd1);
    req_i  = 1'b1;
    data_i = {rw, LW'(len), AW'(addr)};
    id_i   = id;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    forever begin
      if (exp_q.size() == 0) begin
        check_idle("done");
        break;
      end
      chk($sformatf("b%0d.valid", idx), 64'(cmd_valid_o), 64'd1);
      chk($sformatf("b%0d.busy", idx),  64'(busy_o), 64'd1);
      chk($sformatf("b%0d.gnt", idx),   64'(gnt_o), 64'd0);
      chk($sformatf("b%0d.addr", idx),  64'(cmd_addr_o), 64'(exp_q[0].addr));
      chk($sformatf("b%0d.len", idx),   64'(cmd_len_o), 64'(exp_q[0].len));
      chk($sformatf("b%0d.last", idx),  64'(cmd_last_o), 64'(exp_q[0].last));
      chk($sformatf("b%0d.rw", idx),    64'(cmd_rw_o), 64'(rw));
      chk($sformatf("b%0d.id", idx),    64'(cmd_id_o), 64'(id));
      if (idx == abort_at) begin
        rst = 1'b1;
        cmd_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort");
        chk("abort.addr", 64'(cmd_addr_o), 64'd0);
        exp_q.delete();
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      cmd_ready_i = r;
      @(posedge clk);
      if (r) begin
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clk);
      cmd_ready_i = 1'($urandom_range(0, 1)); // ignored while idle
      cyc++;
      if (cyc > 2000) begin
        chk("timeout", 64'(cyc), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; data_i = '0; id_i = '0; cmd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    chk("reset.addr", 64'(cmd_addr_o), 64'd0);
    chk("reset.len",  64'(cmd_len_o),  64'd0);
    chk("reset.rw",   64'(cmd_rw_o),   64'd0);
    chk("reset.id",   64'(cmd_id_o),   64'd0);
    chk("reset.last", 64'(cmd_last_o), 64'd0);

    run_cmd(64'h3F0, 64, 1'b1, 1'b1, 0, -1);
    run_cmd(64'h1000, 300, 1'b0, 1'b0, 1, -1);
    run_cmd(64'hFFFF_FFF8, 16, 1'b0, 1'b1, 0, -1);
    run_cmd(64'h2000, 0, 1'b1, 1'b1, 0, -1);   // discarded, next accepted at once
    run_cmd(64'h2004, 8, 1'b1, 1'b0, 0, -1);
    run_cmd(64'h1000, 300, 1'b0, 1'b1, 0, 1);  // reset during second burst
    run_cmd(64'h5050, 200, 1'b1, 1'b0, 2, -1);
    run_cmd(64'h80, 128, 1'b0, 1'b1, 0, -1);   // exactly one full burst

    for (int i = 0; i < 25; i++) begin
      longint a;
      int l;
      a = (i % 4 == 0) ? longint'(32'hFFFF_FF00 + $urandom_range(0, 255))
                       : longint'($urandom);
      l = (i % 5 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 700));
      run_cmd(a, l, 1'($urandom_range(0, 1)), IW'($urandom_range(0, 1)), 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
